// File: rtl/ili9341_sequencer_pkg.sv
// ili9341_sequencer_pkg: shared state encoding and SPI selector constants for the ILI9341 path
package ili9341_sequencer_pkg;
  typedef enum logic [3:0] {
    IDLE, HW_RST, HW_WAIT, INIT, SETTLE, WIN, PIXELS, FRAME_END, STOPPED, ERROR
  } state_t;
  localparam logic INI_COMM  = 1'b0;
  localparam logic LOOP_COMM = 1'b1;
  localparam logic BUS_CMD   = 1'b0;
  localparam logic BUS_PIX   = 1'b1;
  function automatic int max3(input int a, input int b, input int c);
    return ((a > b ? a : b) > c) ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/ili9341_sequencer_delay_timer.sv
// delay_timer: load-and-count-down timer; o_expired rises on the i_value-th cycle after a load
module delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= i_load ? i_value - W'(1) : (cnt != '0 ? cnt - W'(1) : cnt);
  assign o_expired = cnt == '0;
endmodule

// File: rtl/ili9341_sequencer.sv
// ili9341_sequencer: panel reset, init/settle, then alternating window command and pixel frames
module ili9341_sequencer
  import ili9341_sequencer_pkg::*;
#(
  parameter int RST_LOW_CYC     = 1000,
  parameter int RST_WAIT_CYC    = 6000,
  parameter int SLPOUT_WAIT_CYC = 12000000,
  parameter int PIX_PER_FRAME   = 76800,
  parameter int TIMEOUT_CYC     = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_comm_array_sent,
  input  logic i_pix_sent,
  output logic o_lcd_rst_n,
  output logic o_send_comm_ena,
  output logic o_command,
  output logic o_pix_ena,
  output logic o_bus_sel,
  output logic o_init_done,
  output logic o_frame_done,
  output logic o_busy,
  output logic o_error
);
  localparam int DW = $clog2(max3(RST_LOW_CYC, RST_WAIT_CYC, SLPOUT_WAIT_CYC)) + 1;
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  localparam int PW = $clog2(PIX_PER_FRAME + 1);
  state_t state;
  logic stop_pend, tmr_load, tmr_expired, timeout, enter_win;
  logic [DW-1:0] tmr_value;
  logic [WW-1:0] wd;
  logic [PW-1:0] pix_cnt;
  // the timer loads on the same edge that enters the timed state, so its count is live on the first cycle
  always_comb begin
    tmr_load = (state == IDLE && i_start) || (state == HW_RST && tmr_expired) ||
               (state == INIT && i_comm_array_sent);
    tmr_value = state == IDLE ? DW'(RST_LOW_CYC) :
                state == HW_RST ? DW'(RST_WAIT_CYC) : DW'(SLPOUT_WAIT_CYC);
    timeout = wd == WW'(TIMEOUT_CYC - 1) &&
              ((state == INIT || state == WIN) ? !i_comm_array_sent : (state == PIXELS && !i_pix_sent));
    enter_win = (state == SETTLE && tmr_expired) || (state == FRAME_END && !(stop_pend || i_stop)) ||
                (state == STOPPED && i_start);
  end
  delay_timer #(.W(DW)) u_timer (
    .clk(clk), .rst(rst), .i_load(tmr_load), .i_value(tmr_value), .o_expired(tmr_expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      stop_pend       <= 1'b0;
      wd              <= '0;
      pix_cnt         <= '0;
      o_lcd_rst_n     <= 1'b0;
      o_send_comm_ena <= 1'b0;
      o_command       <= INI_COMM;
      o_pix_ena       <= 1'b0;
      o_bus_sel       <= BUS_CMD;
      o_init_done     <= 1'b0;
      o_frame_done    <= 1'b0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
    end else begin
      o_send_comm_ena <= 1'b0;
      o_frame_done    <= 1'b0;
      stop_pend <= (state == IDLE || state == STOPPED) ? 1'b0 : stop_pend | i_stop;
      wd <= (state == INIT || state == WIN || state == PIXELS) ? wd + WW'(1) : '0;
      if (timeout) begin
        state     <= ERROR;
        o_error   <= 1'b1;
        o_busy    <= 1'b0;
        o_pix_ena <= 1'b0;
        o_bus_sel <= BUS_CMD;
      end else begin
        case (state)
          IDLE: if (i_start) begin
            state  <= HW_RST;
            o_busy <= 1'b1;
          end
          HW_RST: if (tmr_expired) begin
            state       <= HW_WAIT;
            o_lcd_rst_n <= 1'b1;
          end
          HW_WAIT: if (tmr_expired) begin
            state           <= INIT;
            o_command       <= INI_COMM;
            o_send_comm_ena <= 1'b1;
          end
          INIT: if (i_comm_array_sent) state <= SETTLE;
          SETTLE: if (tmr_expired) o_init_done <= 1'b1;
          WIN: if (i_comm_array_sent) begin
            state     <= PIXELS;
            o_bus_sel <= BUS_PIX;
            o_pix_ena <= 1'b1;
            wd        <= '0;
          end
          PIXELS: if (i_pix_sent) begin
            wd      <= '0;
            pix_cnt <= pix_cnt + PW'(1);
            if (pix_cnt == PW'(PIX_PER_FRAME - 1)) begin
              state        <= FRAME_END;
              o_pix_ena    <= 1'b0;
              o_frame_done <= 1'b1;
            end
          end
          FRAME_END: begin
            pix_cnt <= '0;
            if (stop_pend || i_stop) begin
              state     <= STOPPED;
              o_busy    <= 1'b0;
              o_bus_sel <= BUS_CMD;
            end
          end
          STOPPED, ERROR: ;
          default: state <= IDLE;
        endcase
        if (enter_win) begin
          state           <= WIN;
          o_command       <= LOOP_COMM;
          o_send_comm_ena <= 1'b1;
          o_bus_sel       <= BUS_CMD;
          o_busy          <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ili9341_sequencer.sv
// tb_ili9341_sequencer: scoreboard bench; expected command triggers and frame ends are queued by stimulus
module tb_ili9341_sequencer;
  import ili9341_sequencer_pkg::*;
  localparam int PIX = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic i_start = 0, i_stop = 0, i_comm_array_sent = 0, i_pix_sent = 0;
  logic o_lcd_rst_n, o_send_comm_ena, o_command, o_pix_ena, o_bus_sel;
  logic o_init_done, o_frame_done, o_busy, o_error;
  typedef struct packed {logic is_frame; logic cmd; int pix;} exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, pix_seen = 0;
  logic prev_send = 1'b0;

  ili9341_sequencer #(
    .RST_LOW_CYC(4), .RST_WAIT_CYC(6), .SLPOUT_WAIT_CYC(8), .PIX_PER_FRAME(PIX), .TIMEOUT_CYC(32)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_comm_array_sent(i_comm_array_sent), .i_pix_sent(i_pix_sent),
    .o_lcd_rst_n(o_lcd_rst_n), .o_send_comm_ena(o_send_comm_ena), .o_command(o_command),
    .o_pix_ena(o_pix_ena), .o_bus_sel(o_bus_sel), .o_init_done(o_init_done),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    i_start = 1; tick; i_start = 0;
  endtask

  task automatic pulse_comm;
    i_comm_array_sent = 1; tick; i_comm_array_sent = 0;
  endtask

  task automatic pulse_pix;
    i_pix_sent = 1; tick; i_pix_sent = 0;
  endtask

  // monitor: every trigger or frame end must match the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      pix_seen = 0;
      prev_send = 1'b0;
    end else begin
      if (i_pix_sent) pix_seen++;
      if (o_send_comm_ena) begin
        chk("send_width", int'(prev_send), 0);
        chk("send_queued", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("send_kind", int'(e.is_frame), 0);
          chk("send_cmd", int'(o_command), int'(e.cmd));
          chk("send_bus", int'(o_bus_sel), int'(BUS_CMD));
        end
        pix_seen = 0;
      end
      if (o_frame_done) begin
        chk("frame_queued", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("frame_kind", int'(e.is_frame), 1);
          chk("frame_pix", pix_seen, e.pix);
        end
        pix_seen = 0;
      end
      prev_send = o_send_comm_ena;
    end
  end

  task automatic powerup;
    int n;
    q.push_back('{1'b0, INI_COMM, 0});
    pulse_start;
    chk("busy_after_start", int'(o_busy), 1);
    n = 0;
    while (!o_lcd_rst_n && n < 50) begin n++; tick; end
    chk("rst_low_cycles", n, 4);
    n = 0;
    while (!o_send_comm_ena && n < 50) begin n++; tick; end
    chk("rst_wait_cycles", n, 6);
    chk("init_cmd", int'(o_command), int'(INI_COMM));
    tick;
    chk("init_trigger_one_cycle", int'(o_send_comm_ena), 0);
  endtask

  task automatic init_settle;
    int n;
    q.push_back('{1'b0, LOOP_COMM, 0});
    repeat (8) tick;
    pulse_comm;
    chk("init_done_before_settle", int'(o_init_done), 0);
    n = 0;
    while (!o_send_comm_ena && n < 50) begin n++; tick; end
    chk("settle_cycles", n, 8);
    chk("init_done_after_settle", int'(o_init_done), 1);
    chk("loop_cmd", int'(o_command), int'(LOOP_COMM));
  endtask

  task automatic frame(input int stop_at);
    q.push_back('{1'b1, LOOP_COMM, PIX});
    repeat ($urandom_range(0, 3)) tick;
    pulse_comm;
    chk("pixels_bus_sel", int'(o_bus_sel), int'(BUS_PIX));
    chk("pixels_pix_ena", int'(o_pix_ena), 1);
    for (int i = 1; i <= PIX; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      pulse_pix;
      if (i == stop_at) begin i_stop = 1; tick; i_stop = 0; end
    end
    chk("frame_done_pulse", int'(o_frame_done), 1);
    chk("pix_ena_dropped", int'(o_pix_ena), 0);
    if (stop_at == 0) q.push_back('{1'b0, LOOP_COMM, 0});
    tick;
    if (stop_at == 0) begin
      chk("next_win_trigger", int'(o_send_comm_ena), 1);
      chk("win_bus_sel", int'(o_bus_sel), int'(BUS_CMD));
    end else begin
      chk("stopped_busy", int'(o_busy), 0);
      chk("stopped_rst_n", int'(o_lcd_rst_n), 1);
      chk("stopped_bus_sel", int'(o_bus_sel), int'(BUS_CMD));
    end
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tick; tick;
    chk("rst_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("rst_send", int'(o_send_comm_ena), 0);
    chk("rst_command", int'(o_command), int'(INI_COMM));
    chk("rst_pix_ena", int'(o_pix_ena), 0);
    chk("rst_bus_sel", int'(o_bus_sel), 0);
    chk("rst_init_done", int'(o_init_done), 0);
    chk("rst_frame_done", int'(o_frame_done), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_error", int'(o_error), 0);
    rst = 0;
    i_stop = 1; tick; i_stop = 0;
    tick;
    chk("idle_stays_idle", int'(o_busy), 0);
    powerup;
    init_settle;
    frame(0);
    frame(0);
    frame(2);
    repeat (3) tick;
    chk("stopped_no_trigger", int'(o_send_comm_ena), 0);
    q.push_back('{1'b0, LOOP_COMM, 0});
    pulse_start;
    chk("restart_trigger", int'(o_send_comm_ena), 1);
    chk("restart_no_reset_pulse", int'(o_lcd_rst_n), 1);
    n = 0;
    while (!o_error && n < 100) begin n++; tick; end
    chk("timeout_cycles", n, 32);
    chk("error_pix_ena", int'(o_pix_ena), 0);
    chk("error_bus_sel", int'(o_bus_sel), 0);
    chk("error_busy", int'(o_busy), 0);
    pulse_start;
    repeat (5) tick;
    chk("error_sticky", int'(o_error), 1);
    chk("error_ignores_start", int'(o_busy), 0);
    rst = 1;
    #1;
    chk("rst_clears_error", int'(o_error), 0);
    tick; tick;
    rst = 0;
    powerup;
    init_settle;
    pulse_comm;
    for (int i = 0; i < 3; i++) pulse_pix;
    chk("mid_frame_bus_sel", int'(o_bus_sel), 1);
    #3 rst = 1;
    #1;
    chk("async_rst_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("async_rst_bus_sel", int'(o_bus_sel), 0);
    chk("async_rst_pix_ena", int'(o_pix_ena), 0);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_init_done", int'(o_init_done), 0);
    tick; tick;
    rst = 0;
    powerup;
    repeat (3) tick;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
